switch_operand_capture: RTL and testbench

Front-end stage that sits directly upstream of the LED 2-bit adder. It synchronises and debounces the four raw board switches. It presents two clean, registered 2-bit operands (op_a = {sw2,sw1}, op_b = {sw4,sw3}) to the adder. It also gives per-switch press pulses and an operand-changed strobe for later display and sequencing logic.

---
 rtl/switch_operand_capture_pkg.sv | 18 +
 rtl/switch_operand_capture_if.sv | 24 ++
 rtl/switch_operand_capture_debounce_filter.sv | 54 +++++
 rtl/switch_operand_capture.sv | 45 ++++
 tb/tb_switch_operand_capture.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/switch_operand_capture_pkg.sv
// Shared constants for the switch front-end: channel count, operand width and
// which debounced switch bits form each adder operand.
package switch_operand_capture_pkg;

   localparam int SW_COUNT            = 4;
   localparam int OP_W                = 2;
   localparam int DEBOUNCE_CYCLES_DEF = 250000;   // 10 ms at 25 MHz

   // Operand A = {sw2, sw1}, operand B = {sw4, sw3}; indices into the switch vector
   localparam int A_LO_IDX = 0;
   localparam int A_HI_IDX = 1;
   localparam int B_LO_IDX = 2;
   localparam int B_HI_IDX = 3;

   typedef logic [OP_W-1:0]     op_t;
   typedef logic [SW_COUNT-1:0] sw_vec_t;

endpackage

// File: rtl/switch_operand_capture_if.sv
// Raw switch inputs toward the capture block and its clean operand/strobe outputs.
interface switch_operand_capture_if;
   import switch_operand_capture_pkg::*;

   logic    sw1_i;
   logic    sw2_i;
   logic    sw3_i;
   logic    sw4_i;
   op_t     op_a_o;
   op_t     op_b_o;
   sw_vec_t press_o;
   logic    op_valid_o;

   modport master (
      output sw1_i, sw2_i, sw3_i, sw4_i,
      input  op_a_o, op_b_o, press_o, op_valid_o
   );

   modport slave (
      input  sw1_i, sw2_i, sw3_i, sw4_i,
      output op_a_o, op_b_o, press_o, op_valid_o
   );

endinterface

// File: rtl/switch_operand_capture_debounce_filter.sv
// One switch channel: 2-flop synchroniser, mismatch counter, stable level and rise pulse.
// Level moves DEBOUNCE_CYCLES+2 edges after a held input change; no backpressure.
module debounce_filter
   import switch_operand_capture_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sw_i,
   output logic level_o,
   output logic rise_o,
   output logic upd_o
);

   localparam int             CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1;
   logic             s2;
   logic             stable;
   logic [CNT_W-1:0] cnt;

   // Early strobe: the stable level flips on the coming edge
   assign upd_o   = (s2 != stable) && (cnt == LAST);
   assign level_o = stable;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         stable <= 1'b0;
         cnt    <= '0;
         rise_o <= 1'b0;
      end else begin
         s1     <= sw_i;
         s2     <= s1;
         rise_o <= 1'b0;
         if (s2 != stable) begin
            if (cnt == LAST) begin
               stable <= s2;
               cnt    <= '0;
               rise_o <= s2;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end else begin
            // Any bounce back to the accepted level restarts the count
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/switch_operand_capture.sv
// Debounces four board switches into two registered 2-bit adder operands plus press/changed strobes.
// Operands move DEBOUNCE_CYCLES+2 edges after a held switch change; no backpressure.
module switch_operand_capture
   import switch_operand_capture_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   switch_operand_capture_if.slave  bus
);

   sw_vec_t sw_raw;
   sw_vec_t level;
   sw_vec_t rise;
   sw_vec_t upd;
   logic    op_valid_q;

   assign sw_raw = {bus.sw4_i, bus.sw3_i, bus.sw2_i, bus.sw1_i};

   for (genvar i = 0; i < SW_COUNT; i++) begin : g_ch
      debounce_filter #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_db (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .sw_i    (sw_raw[i]),
         .level_o (level[i]),
         .rise_o  (rise[i]),
         .upd_o   (upd[i])
      );
   end

   // Several channels settling on one edge still give a single strobe
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) op_valid_q <= 1'b0;
      else       op_valid_q <= |upd;
   end

   assign bus.op_a_o     = {level[A_HI_IDX], level[A_LO_IDX]};
   assign bus.op_b_o     = {level[B_HI_IDX], level[B_LO_IDX]};
   assign bus.press_o    = rise;
   assign bus.op_valid_o = op_valid_q;

endmodule

// File: tb/tb_switch_operand_capture.sv
// Directed bench for switch_operand_capture with a 4-cycle debounce window.
module tb_switch_operand_capture;

   localparam int DC = 4;

   logic clk_i = 1'b0;
   logic rst_i;
   int   n_checks = 0;
   int   n_fail   = 0;

   switch_operand_capture_if bus ();

   switch_operand_capture #(.DEBOUNCE_CYCLES(DC)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus.slave)
   );

   always #5 clk_i = ~clk_i;

   // Observed vector {op_a, op_b, press, op_valid}
   function automatic logic [8:0] obs();
      return {bus.op_a_o, bus.op_b_o, bus.press_o, bus.op_valid_o};
   endfunction

   task automatic set_sw(input logic [3:0] v);
      bus.sw1_i = v[0];
      bus.sw2_i = v[1];
      bus.sw3_i = v[2];
      bus.sw4_i = v[3];
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      set_sw(4'b0000);
      #2 rst_i = 1'b1;
      #1;
      n_checks++;
      if (obs() !== 9'b0) begin
         n_fail++;
         $display("FAIL reset_async: got %b want %b", obs(), 9'b0);
      end
      for (int k = 1; k <= 10; k++) begin
         set_sw(4'(k * 5));
         step();
         n_checks++;
         if (obs() !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_hold edge %0d: got %b want %b", k, obs(), 9'b0);
         end
      end
      set_sw(4'b0000);
      step();
      rst_i = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         n_checks++;
         if (obs() !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_idle edge %0d: got %b want %b", k, obs(), 9'b0);
         end
      end
   endtask

   task automatic test_sw1_rise();
      logic [8:0] exp;
      set_sw(4'b0001);
      for (int k = 1; k <= 9; k++) begin
         step();
         exp = {(k >= 6) ? 2'b01 : 2'b00, 2'b00, (k == 6) ? 4'b0001 : 4'b0000, k == 6};
         n_checks++;
         if (obs() !== exp) begin
            n_fail++;
            $display("FAIL sw1_rise edge %0d: got %b want %b", k, obs(), exp);
         end
      end
   endtask

   task automatic test_sw3_bounce();
      logic [8:0] exp;
      for (int k = 1; k <= 13; k++) begin
         set_sw((k == 4) ? 4'b0001 : 4'b0101);
         step();
         exp = {2'b01, (k >= 10) ? 2'b01 : 2'b00, (k == 10) ? 4'b0100 : 4'b0000, k == 10};
         n_checks++;
         if (obs() !== exp) begin
            n_fail++;
            $display("FAIL sw3_bounce edge %0d: got %b want %b", k, obs(), exp);
         end
      end
   endtask

   task automatic test_sw1_release();
      logic [8:0] exp;
      set_sw(4'b0100);
      for (int k = 1; k <= 9; k++) begin
         step();
         exp = {(k >= 6) ? 2'b00 : 2'b01, 2'b01, 4'b0000, k == 6};
         n_checks++;
         if (obs() !== exp) begin
            n_fail++;
            $display("FAIL sw1_release edge %0d: got %b want %b", k, obs(), exp);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [8:0] exp;
      set_sw(4'b0000);
      for (int k = 1; k <= 8; k++) step();
      n_checks++;
      if (obs() !== 9'b0) begin
         n_fail++;
         $display("FAIL sim_pre: got %b want %b", obs(), 9'b0);
      end
      set_sw(4'b1010);
      for (int k = 1; k <= 9; k++) begin
         step();
         exp = {(k >= 6) ? 4'b1010 : 4'b0000, (k == 6) ? 4'b1010 : 4'b0000, k == 6};
         n_checks++;
         if (obs() !== exp) begin
            n_fail++;
            $display("FAIL simultaneous edge %0d: got %b want %b", k, obs(), exp);
         end
      end
   endtask

   task automatic test_async_clear();
      step();
      #3 rst_i = 1'b1;
      #1;
      n_checks++;
      if (obs() !== 9'b0) begin
         n_fail++;
         $display("FAIL async_clear: got %b want %b", obs(), 9'b0);
      end
      set_sw(4'b0000);
      for (int k = 1; k <= 3; k++) step();
      rst_i = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         n_checks++;
         if (obs() !== 9'b0) begin
            n_fail++;
            $display("FAIL async_idle edge %0d: got %b want %b", k, obs(), 9'b0);
         end
      end
   endtask

   task automatic test_reset_mid_count();
      logic [8:0] exp;
      set_sw(4'b1000);
      for (int k = 1; k <= 5; k++) begin
         step();
         n_checks++;
         if (obs() !== 9'b0) begin
            n_fail++;
            $display("FAIL mid_count edge %0d: got %b want %b", k, obs(), 9'b0);
         end
      end
      #3 rst_i = 1'b1;
      #1;
      n_checks++;
      if (obs() !== 9'b0) begin
         n_fail++;
         $display("FAIL mid_count_rst: got %b want %b", obs(), 9'b0);
      end
      step();
      rst_i = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         step();
         exp = {2'b00, (k >= 6) ? 2'b10 : 2'b00, (k == 6) ? 4'b1000 : 4'b0000, k == 6};
         n_checks++;
         if (obs() !== exp) begin
            n_fail++;
            $display("FAIL after_release edge %0d: got %b want %b", k, obs(), exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sw1_rise();
      test_sw3_bounce();
      test_sw1_release();
      test_simultaneous();
      test_async_clear();
      test_reset_mid_count();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
